// File: rtl/aes_key_sched_seq.sv
// aes_key_sched_seq: sequential AES-128 key expander.
// Builds the 11 round keys one per clock into a registered schedule bus and
// offers a registered single-round read port.
// Optional feature: define AES_KEYSCHED_ZEROIZE_EN to add a synchronous
// `clear` input and to wipe rounds 1..10 whenever a new expansion starts.
module aes_key_sched_seq (
    input  logic          clk,
    input  logic          rst_n,
`ifdef AES_KEYSCHED_ZEROIZE_EN
    input  logic          clear,
`endif
    input  logic          start,
    input  logic [0:127]  key,
    output logic          busy,
    output logic          done,
    output logic          valid,
    output logic [0:1407] key_schedule,
    input  logic [3:0]    rd_round,
    output logic [0:127]  rd_key
);

    // Forward S-box, same table as the SubBytes stage; entry b sits at
    // bits [8*b +: 8] counting from the leftmost byte.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic          start_acc;
    logic          last_rnd;
    logic          clr_sync;
    logic [3:0]    rnd;
    logic [7:0]    rcon;
    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   temp, w0_n, w1_n, w2_n, w3_n;
    logic [127:0]  sched [0:10];
    logic [127:0]  rd_sel;

`ifdef AES_KEYSCHED_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
    assign clr_sync = clear;
`else
    localparam bit ZEROIZE = 1'b0;
    assign clr_sync = 1'b0;
`endif

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One round of the AES-128 word recurrence from the current word registers.
    always_comb begin
        temp = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
        w0_n = w0 ^ temp;
        w1_n = w1 ^ w0_n;
        w2_n = w2 ^ w1_n;
        w3_n = w3 ^ w2_n;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values, independent of block ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode: accept start only in IDLE, finish after round 10.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        start_acc = 1'b0;
        last_rnd  = 1'b0;
        if (clr_sync) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        start_acc = 1'b1;
                        state_nxt = EXPAND;
                    end
                end
                EXPAND: begin
                    if (rnd == 4'd10) begin
                        last_rnd  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // Read-port mux; out-of-range rounds read as zero.
    always_comb begin
        rd_sel = '0;
        if (rd_round <= 4'd10) rd_sel = sched[rd_round];
    end

    // Schedule, word registers, round counter, rcon and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the schedule array is reset because the bus is an
            // architectural output that must read all-zero after reset.
            for (int i = 0; i <= 10; i++) sched[i] <= '0;
            {w0, w1, w2, w3} <= '0;
            rnd    <= '0;
            rcon   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
            rd_key <= '0;
        end else if (clr_sync) begin
            for (int i = 0; i <= 10; i++) sched[i] <= '0;
            {w0, w1, w2, w3} <= '0;
            rnd    <= '0;
            rcon   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
            rd_key <= '0;
        end else begin
            // Reads see the schedule as it was before this edge's write.
            rd_key <= rd_sel;
            done   <= 1'b0;
            if (start_acc) begin
                if (ZEROIZE) begin
                    for (int i = 1; i <= 10; i++) sched[i] <= '0;
                end
                sched[0] <= key;
                w0       <= key[0:31];
                w1       <= key[32:63];
                w2       <= key[64:95];
                w3       <= key[96:127];
                rnd      <= 4'd1;
                rcon     <= 8'h01;
                busy     <= 1'b1;
                valid    <= 1'b0;
            end else if (state == EXPAND) begin
                sched[rnd] <= {w0_n, w1_n, w2_n, w3_n};
                w0         <= w0_n;
                w1         <= w1_n;
                w2         <= w2_n;
                w3         <= w3_n;
                rcon       <= xtime(rcon);
                rnd        <= rnd + 4'd1;
                if (last_rnd) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    valid <= 1'b1;
                end
            end
        end
    end

    // Flatten the schedule: round 0 occupies the leftmost 128 bits.
    assign key_schedule = {sched[0], sched[1], sched[2], sched[3], sched[4], sched[5],
                           sched[6], sched[7], sched[8], sched[9], sched[10]};

endmodule
